// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
package reg_file_sb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-writeback flag per register plus a registered population count.
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;

  // Clear is applied first so a same-index set (the new producer) wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with registered reads, same-edge write bypass and a busy scoreboard.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [NUM_REGS-1:0]      busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam logic [ADDR_W:0] IDX_LIMIT = (ADDR_W+1)'(NUM_REGS);

  // An index is usable when it is in range and not the hard-wired zero register.
  function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < IDX_LIMIT);
    is_zero  = (ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX));
    return in_range && !is_zero;
  endfunction

  logic              wr_ok;
  logic              sb_ok;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] rd_idx [NUM_RD];
  logic [DATA_W-1:0] rd_data_p0 [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_p0;
  logic [DATA_W-1:0] rd_data_p1 [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_p1;

  assign wr_ok = wr_en && idx_ok(wr_addr);
  assign sb_ok = sb_set && idx_ok(sb_addr);

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .set_en   (sb_ok),
    .set_addr (sb_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    assign rd_idx[k]                   = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] = rd_data_p1[k];
  end
  assign rd_busy = rd_busy_p1;

  // p0: read select; a same-edge write bypasses storage and retires the busy flag.
  always_comb begin
    rd_busy_p0 = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data_p0[k] = '0;
      if (idx_ok(rd_idx[k])) begin
        if (wr_ok && (wr_addr == rd_idx[k])) begin
          rd_data_p0[k] = wr_data;
        end else begin
          rd_data_p0[k] = regs[rd_idx[k]];
          rd_busy_p0[k] = busy[rd_idx[k]];
        end
      end
    end
  end

  // p1: registered read outputs, held while the port's strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_RD; k++) rd_data_p1[k] <= '0;
      rd_busy_p1 <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        if (rd_en[k]) begin
          rd_data_p1[k] <= rd_data_p0[k];
          rd_busy_p1[k] <= rd_busy_p0[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed bench for reg_file_sb against a behavioural register/scoreboard model.
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [NRD-1:0]    rd_en = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              sb_set = 1'b0;
  logic [AW-1:0]     sb_addr = '0;
  logic [NR-1:0]     busy;
  logic [AW:0]       busy_cnt;

  reg_file_sb #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] m_reg [NR];
  bit            m_busy [NR];
  logic [DW-1:0] m_rd [NRD];
  bit            m_rb [NRD];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    for (int p = 0; p < NRD; p++) begin
      m_rd[p] = '0;
      m_rb[p] = 1'b0;
    end
  endtask

  // Apply the architectural rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit we;
    int a;
    if (!rst_n) return;
    we = wr_en && (wr_addr != 0);
    for (int p = 0; p < NRD; p++) begin
      if (rd_en[p]) begin
        a = int'(rd_addr[p*AW +: AW]);
        if (a == 0) begin
          m_rd[p] = '0;
          m_rb[p] = 1'b0;
        end else if (we && int'(wr_addr) == a) begin
          m_rd[p] = wr_data;
          m_rb[p] = 1'b0;
        end else begin
          m_rd[p] = m_reg[a];
          m_rb[p] = m_busy[a];
        end
      end
    end
    if (we) begin
      m_reg[wr_addr]  = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
  endtask

  task automatic compare_all(input string ctx);
    logic [NR-1:0] eb;
    int            ec;
    eb = '0;
    ec = 0;
    for (int i = 0; i < NR; i++) begin
      eb[i] = m_busy[i];
      ec    = ec + int'(m_busy[i]);
    end
    check_val({ctx, ".rd0"}, 64'(rd_data[31:0]), 64'(m_rd[0]));
    check_val({ctx, ".rd1"}, 64'(rd_data[63:32]), 64'(m_rd[1]));
    check_val({ctx, ".rbusy"}, 64'(rd_busy), 64'({m_rb[1], m_rb[0]}));
    check_val({ctx, ".busy"}, 64'(busy), 64'(eb));
    check_val({ctx, ".cnt"}, 64'(busy_cnt), 64'(ec));
  endtask

  task automatic tick(input string ctx);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(ctx);
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rd_en  = '0;
    sb_set = 1'b0;
  endtask

  task automatic set_rd(input int p, input reg_idx_t a);
    rd_en[p]            = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic do_write(input reg_idx_t a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic do_sb(input reg_idx_t a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  function automatic reg_idx_t rnd_addr();
    if ($urandom_range(0, 3) == 0) return reg_idx_t'($urandom_range(0, NR-1));
    return reg_idx_t'($urandom_range(0, 7));
  endfunction

  task automatic rnd_ops();
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = rnd_addr();
    wr_data = $urandom;
    rd_en   = NRD'($urandom_range(0, 3));
    rd_addr = {rnd_addr(), rnd_addr()};
    sb_set  = 1'($urandom_range(0, 1));
    sb_addr = rnd_addr();
  endtask

  // Assert reset between edges, check the asynchronous clear, and hold traffic that must be ignored.
  task automatic do_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val({ctx, ".busy0"}, 64'(busy), 64'd0);
    check_val({ctx, ".cnt0"}, 64'(busy_cnt), 64'd0);
    check_val({ctx, ".rdata0"}, 64'(rd_data), 64'd0);
    compare_all(ctx);
    for (int i = 0; i < 2; i++) begin
      rnd_ops();
      tick({ctx, ".held"});
    end
    #2;
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    compare_all("reset");
    for (int i = 0; i < 2; i++) begin
      rnd_ops();
      tick("in_reset");
    end
    #2;
    rst_n = 1'b1;
    idle();

    // Write then read back on port 0.
    do_write(5, 32'hDEADBEEF);
    tick("w5");
    idle();
    set_rd(0, 5);
    tick("r5");
    check_val("wr_rd_r5", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);

    // Same-edge bypass on port 1.
    idle();
    do_write(7, 32'h12345678);
    set_rd(1, 7);
    tick("byp7");
    check_val("bypass_r7", 64'(rd_data[63:32]), 64'h1234_5678);

    // Zero register ignores writes and scoreboard sets.
    idle();
    do_write(0, 32'hFFFFFFFF);
    set_rd(0, 0);
    set_rd(1, 0);
    tick("w0");
    check_val("r0_data", 64'(rd_data), 64'd0);
    check_val("r0_rbusy", 64'(rd_busy), 64'd0);
    idle();
    do_sb(0);
    set_rd(0, 0);
    tick("sb0");
    check_val("sb_r0", 64'(busy[0]), 64'd0);
    check_val("sb_r0_cnt", 64'(busy_cnt), 64'd0);

    // Scoreboard set, flagged read, and set-wins on collision with write.
    idle();
    do_sb(3);
    tick("sb3");
    check_val("sb3_bit", 64'(busy[3]), 64'd1);
    check_val("sb3_cnt", 64'(busy_cnt), 64'd1);
    idle();
    set_rd(0, 3);
    tick("rd3");
    check_val("rd3_busy", 64'(rd_busy[0]), 64'd1);
    idle();
    do_write(3, 32'hA5A5_0003);
    do_sb(3);
    tick("wsb3");
    check_val("wsb3_bit", 64'(busy[3]), 64'd1);
    check_val("wsb3_cnt", 64'(busy_cnt), 64'd1);
    idle();
    do_write(3, 32'h0000_3333);
    set_rd(1, 3);
    tick("clr3");
    check_val("clr3_rbusy", 64'(rd_busy[1]), 64'd0);
    check_val("clr3_cnt", 64'(busy_cnt), 64'd0);

    // Three pending producers, then a mid-stream reset.
    idle();
    do_sb(1);
    tick("sb1");
    do_sb(2);
    tick("sb2");
    do_sb(4);
    tick("sb4");
    check_val("sb3x_cnt", 64'(busy_cnt), 64'd3);
    idle();
    do_reset("midrst");

    // Read strobe low holds the previous value across a rewrite.
    do_write(9, 32'hCAFE_0009);
    tick("w9a");
    idle();
    set_rd(0, 9);
    tick("r9a");
    idle();
    do_write(9, 32'hBEEF_0909);
    tick("w9b");
    check_val("hold_r9", 64'(rd_data[31:0]), 64'h0000_0000_CAFE_0009);
    idle();
    set_rd(0, 9);
    set_rd(1, 9);
    do_sb(9);
    tick("r9both");
    check_val("dual_r9", 64'(rd_data[63:32]), 64'(rd_data[31:0]) ^ 64'h0 ^ 64'(32'hBEEF_0909) ^ 64'(rd_data[31:0]));
    check_val("dual_r9_flag", 64'(rd_busy[1]), 64'(rd_busy[0]));

    // Randomized traffic with a reset in the middle.
    for (int it = 0; it < 400; it++) begin
      if (it == 200) begin
        idle();
        do_reset("rnd_rst");
      end
      rnd_ops();
      tick("rnd");
    end

    idle();
    tick("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the register count; ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL make register 0 hard-wired zero when 1.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-006 wr_en  in  1  write strobe; wr_addr  in  ADDR_W  write index; wr_data  in  DATA_W  write value.
REQ-007 rd_en  in  NUM_RD  per-port read strobe; rd_addr  in  NUM_RD*ADDR_W  packed read indices, port k at [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  out  NUM_RD*DATA_W  packed registered read data; rd_busy  out  NUM_RD  per-port "operand pending" flag.
REQ-009 sb_set  in  1  marks a register as awaiting writeback; sb_addr  in  ADDR_W  its index.
REQ-010 busy  out  NUM_REGS  live scoreboard vector; busy_cnt  out  ADDR_W+1  number of set busy bits.

Function
REQ-011 A write SHALL commit on the rising clk edge when wr_en=1; writes to register 0 SHALL be dropped when ZERO_REG=1.
REQ-012 Each read port SHALL have a latency of 1: rd_data[k] updates on the edge where rd_en[k]=1 and holds its value while rd_en[k]=0.
REQ-013 Same-edge bypass: if rd_en[k]=1, wr_en=1 and rd_addr[k]=wr_addr (and the write is not dropped), rd_data[k] SHALL take wr_data, not the old contents.
REQ-014 Reads of register 0 with ZERO_REG=1 SHALL return 0 and rd_busy 0 regardless of other inputs.
REQ-015 Scoreboard: sb_set=1 SHALL set busy[sb_addr]; a committed write SHALL clear busy[wr_addr].
REQ-016 Simultaneous sb_set and write to the same index SHALL leave the bit set (the new producer wins); to different indices, both SHALL apply.
REQ-017 sb_set to register 0 with ZERO_REG=1 SHALL be ignored.
REQ-018 rd_busy[k] SHALL be registered alongside rd_data[k] and reflect busy[rd_addr[k]] after the same edge's write-clear, before the same edge's set.
REQ-019 busy_cnt SHALL equal the population count of busy, registered, and updated on the same edge as busy.
REQ-020 Multiple read ports addressing the same index SHALL each return identical data and flags.
REQ-021 Out-of-range addresses (>= NUM_REGS when NUM_REGS is not a power of 2) SHALL read 0 and ignore writes and sb_set.

Reset
REQ-022 rst_n=0 SHALL asynchronously clear all registers, rd_data, rd_busy, busy and busy_cnt to 0.
REQ-023 Writes, reads and sb_set presented while rst_n=0 SHALL have no effect; the first accepted operation is on the first rising edge with rst_n=1.
REQ-024 Reset asserted mid-stream SHALL discard all pending busy bits without completing any write.

Structure
REQ-025 Shared package: default DATA_W/NUM_REGS/NUM_RD constants, the register-index typedef, and the zero-register index constant.
REQ-026 The scoreboard (busy vector, busy_cnt, set/clear priority) SHALL be a sub-module named reg_scoreboard; storage and read ports stay in reg_file_sb.

Verification
REQ-027 Reset, then write 0xDEADBEEF to r5; next cycle read r5 on port 0 -> rd_data[0]=0xDEADBEEF one edge later.
REQ-028 Same edge: write 0x12345678 to r7, port 1 reads r7 -> rd_data[1]=0x12345678 (bypass), not the prior value 0.
REQ-029 Write 0xFFFFFFFF to r0, read r0 on both ports -> both read 0, rd_busy=0; sb_set r0 -> busy[0] stays 0.
REQ-030 sb_set r3 -> busy[3]=1, busy_cnt=1; read r3 -> rd_busy=1; write r3 with sb_set r3 same edge -> busy[3] stays 1, busy_cnt=1.
REQ-031 sb_set r1, r2, r4 over 3 cycles -> busy_cnt=3; assert rst_n=0 mid-cycle -> busy=0, busy_cnt=0, rd_data=0 immediately.
REQ-032 Port 0 reads r9 with rd_en[0]=1, then rd_en[0]=0 while r9 is rewritten -> rd_data[0] holds the old value.
